segment_sequencer: RTL and testbench
====================================

# segment_sequencer

Parametrised fragment sequencer for the SDRAM-based TCAM segment engine. It walks a configurable number of key fragments through a shift / settle / SDRAM read / modify / SDRAM write loop for setting, or a shift / settle / read loop for searching. It exports the active fragment index for address generation and uses standard Avalon-MM handshakes. It adds a response timeout with error reporting and a programmable settle delay.

## Interface
- FRAGMENTS, 5: fragments per operation, 1..255.
- STABLE_CYCLES, 2: settle cycles after each shift, 1..15.
- TIMEOUT_CYCLES, 1023: maximum cycles waiting on readdatavalid or modify_done, 1..65535.
- IDX_W, $clog2(FRAGMENTS)>0 ? $clog2(FRAGMENTS) : 1: fragment index width.
- clk  in  1  Single clock for the block.
- reset_n  in  1  Asynchronous, active-low reset.
- i_setting_enable  in  1  Starts a setting operation; sampled only in IDLE.
- i_search_enable  in  1  Starts a search operation; sampled only in IDLE. Setting has priority.
- i_sdram_waitrequest  in  1  Avalon waitrequest.
- i_sdram_readdatavalid  in  1  Avalon readdatavalid.
- o_sdram_read  out  1  Avalon read request.
- o_sdram_write  out  1  Avalon write request.
- i_cntl_m0_modify_done  in  1  Datapath modify finished.
- i_search_miss  in  1  Datapath reports a definite miss. Used only with the early-exit feature.
- o_cntl_m0_load  out  1  Combinational: high while in IDLE and reset_n=1.
- o_cntl_m0_shift  out  1  One-cycle fragment shift pulse.
- o_cntl_m0_modify  out  1  Modify request.
- o_cntl_m0_searchdatavalid  out  1  One-cycle pulse on a search read return.
- o_frag_idx  out  IDX_W  Index of the current fragment, 0..FRAGMENTS-1.
- o_busy  out  1  High in every state except IDLE.
- o_search_complete  out  1  High while no search is in progress.
- o_setting_complete  out  1  High while no setting is in progress.
- o_done  out  1  One-cycle pulse when an operation ends, successfully or not.
- o_error  out  1  Sticky timeout flag. Cleared at the next start.

## Operation
- Reset values:
  - All registered outputs are 0, o_frag_idx is 0, state is IDLE.
  - o_search_complete and o_setting_complete are 1 once reset is released.
  - o_cntl_m0_load is 1 once reset is released.
- IDLE: on a start request, latch the mode, clear o_error, set index to 0, go to SHIFT.
- SHIFT: pulse o_cntl_m0_shift, load the settle counter, go to STABLE.
- STABLE: hold for STABLE_CYCLES cycles, then go to RD_REQ.
- RD_REQ:
  - Assert o_sdram_read and hold it while i_sdram_waitrequest=1.
  - In the first cycle with waitrequest=0, deassert read and go to RD_WAIT.
- RD_WAIT, on i_sdram_readdatavalid:
  - Setting mode: go to MODIFY.
  - Search mode: pulse o_cntl_m0_searchdatavalid, go to COUNT.
- MODIFY: hold o_cntl_m0_modify=1 until i_cntl_m0_modify_done, then drop it and go to STABLE_WR.
- STABLE_WR: one cycle, then go to WRITE.
- WRITE: hold o_sdram_write while waitrequest=1. On waitrequest=0, deassert write and go to COUNT.
- COUNT:
  - If index < FRAGMENTS-1: increment index, go to SHIFT.
  - Otherwise: pulse o_done, clear the mode flags, return to IDLE.
- Timeout:
  - The counter runs in RD_WAIT and MODIFY and is reloaded on entry to each.
  - On expiry: set o_error, deassert all requests, pulse o_done, clear the modes, return to IDLE.
- Readdatavalid arriving outside RD_WAIT is ignored.
- Start requests are ignored while o_busy=1.

## Timing
- Per-fragment latency with zero waitrequest and immediate responses:
  - Search: 1 (SHIFT) + STABLE_CYCLES + 1 (RD_REQ) + 1 (RD_WAIT) + 1 (COUNT).
  - Setting: the search figure plus 1 (MODIFY) + 1 (STABLE_WR) + 1 (WRITE).
- With defaults: search totals 30 cycles from start to o_done, setting totals 45.
- o_frag_idx is stable from SHIFT through COUNT of the same fragment.
- Asserting reset_n low in any state forces the reset values immediately. No o_done pulse is issued.

## Configuration
- SEGSEQ_EARLY_EXIT_EN defined:
  - In search mode, i_search_miss=1 sampled in COUNT ends the operation at once: pulse o_done, return to IDLE, skip the remaining fragments.
  - o_error is not set.
- Undefined: i_search_miss is ignored and all FRAGMENTS fragments are always processed.

## Test plan
- Reset, then release: all requests 0, o_cntl_m0_load=1, both complete flags=1, o_frag_idx=0.
- Search, defaults, zero waitrequest, readdatavalid one cycle after the read: exactly 5 searchdatavalid pulses with o_frag_idx 0..4, o_done at cycle 30.
- Setting with waitrequest held 3 cycles on each read and write: read/write stay high 4 cycles per access, 5 modify cycles, final o_done with o_error=0.
- readdatavalid withheld, TIMEOUT_CYCLES=8: o_error=1 nine cycles after RD_WAIT entry, o_done pulse, IDLE. The next start clears o_error.
- Setting and search requested in the same cycle: setting mode runs. A second start while busy is ignored.
- With SEGSEQ_EARLY_EXIT_EN, miss asserted at fragment 1: o_done after 2 fragments. Without the macro: 5 fragments processed.

Source files
------------

// File: rtl/segment_sequencer.sv
// segment_sequencer: walks FRAGMENTS key fragments of the SDRAM-based TCAM
// segment engine through shift / settle / read (/ modify / write) loops.
// Request outputs are registered from the next state, so each one is high for
// exactly the cycles spent in its state and drops on the edge that leaves it.
// Optional feature macro: SEGSEQ_EARLY_EXIT_EN (search ends early on a miss).
module segment_sequencer #(
    parameter int FRAGMENTS      = 5,
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int IDX_W          = ($clog2(FRAGMENTS) > 0) ? $clog2(FRAGMENTS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_setting_enable,
    input  logic             i_search_enable,
    input  logic             i_sdram_waitrequest,
    input  logic             i_sdram_readdatavalid,
    output logic             o_sdram_read,
    output logic             o_sdram_write,
    input  logic             i_cntl_m0_modify_done,
    input  logic             i_search_miss,
    output logic             o_cntl_m0_load,
    output logic             o_cntl_m0_shift,
    output logic             o_cntl_m0_modify,
    output logic             o_cntl_m0_searchdatavalid,
    output logic [IDX_W-1:0] o_frag_idx,
    output logic             o_busy,
    output logic             o_search_complete,
    output logic             o_setting_complete,
    output logic             o_done,
    output logic             o_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_SHIFT, S_STABLE, S_RD_REQ, S_RD_WAIT,
        S_MODIFY, S_STABLE_WR, S_WRITE, S_COUNT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       settle_q;
    logic [15:0]      tmo_q;
    logic             setting_mode_q, search_mode_q;
    logic             start, last_frag, early_exit, timeout_hit;
    logic             read_d, write_d, shift_d, modify_d, busy_d, sdv_d, done_d;

    assign start     = i_setting_enable | i_search_enable;
    assign last_frag = (idx_q == IDX_W'(FRAGMENTS - 1));

`ifdef SEGSEQ_EARLY_EXIT_EN
    assign early_exit = search_mode_q & i_search_miss;
`else
    logic unused_search_miss;
    assign unused_search_miss = i_search_miss;
    assign early_exit = 1'b0;
`endif

    // The wait counter reaching zero with no response means RD_WAIT/MODIFY has
    // lasted TIMEOUT_CYCLES cycles; o_error shows up in the following cycle.
    assign timeout_hit = (tmo_q == 16'd0) &&
                         (((state_q == S_RD_WAIT) && !i_sdram_readdatavalid) ||
                          ((state_q == S_MODIFY)  && !i_cntl_m0_modify_done));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_SHIFT;
            S_SHIFT:     state_d = S_STABLE;
            S_STABLE:    if (settle_q == 4'd0) state_d = S_RD_REQ;
            S_RD_REQ:    if (!i_sdram_waitrequest) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (i_sdram_readdatavalid) state_d = setting_mode_q ? S_MODIFY : S_COUNT;
                else if (timeout_hit)      state_d = S_IDLE;
            end
            S_MODIFY: begin
                if (i_cntl_m0_modify_done) state_d = S_STABLE_WR;
                else if (timeout_hit)      state_d = S_IDLE;
            end
            S_STABLE_WR: state_d = S_WRITE;
            S_WRITE:     if (!i_sdram_waitrequest) state_d = S_COUNT;
            S_COUNT:     state_d = (last_frag || early_exit) ? S_IDLE : S_SHIFT;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs
    always_comb begin
        read_d   = (state_d == S_RD_REQ);
        write_d  = (state_d == S_WRITE);
        shift_d  = (state_d == S_SHIFT);
        modify_d = (state_d == S_MODIFY);
        busy_d   = (state_d != S_IDLE);
        sdv_d    = (state_q == S_RD_WAIT) && i_sdram_readdatavalid && search_mode_q;
        done_d   = ((state_q == S_COUNT) && (state_d == S_IDLE)) || timeout_hit;
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_sdram_read              <= 1'b0;
            o_sdram_write             <= 1'b0;
            o_cntl_m0_shift           <= 1'b0;
            o_cntl_m0_modify          <= 1'b0;
            o_cntl_m0_searchdatavalid <= 1'b0;
            o_busy                    <= 1'b0;
            o_done                    <= 1'b0;
        end else begin
            o_sdram_read              <= read_d;
            o_sdram_write             <= write_d;
            o_cntl_m0_shift           <= shift_d;
            o_cntl_m0_modify          <= modify_d;
            o_cntl_m0_searchdatavalid <= sdv_d;
            o_busy                    <= busy_d;
            o_done                    <= done_d;
        end
    end

    // Fragment index, settle and response-timeout counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q    <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
        end else begin
            if ((state_q == S_IDLE) && start)
                idx_q <= '0;
            else if ((state_q == S_COUNT) && (state_d == S_SHIFT))
                idx_q <= idx_q + IDX_W'(1);

            if (state_q == S_SHIFT)
                settle_q <= 4'(STABLE_CYCLES - 1);
            else if ((state_q == S_STABLE) && (settle_q != 4'd0))
                settle_q <= settle_q - 4'd1;

            if (((state_d == S_RD_WAIT) && (state_q != S_RD_WAIT)) ||
                ((state_d == S_MODIFY)  && (state_q != S_MODIFY)))
                tmo_q <= 16'(TIMEOUT_CYCLES - 1);
            else if (((state_q == S_RD_WAIT) || (state_q == S_MODIFY)) && (tmo_q != 16'd0))
                tmo_q <= tmo_q - 16'd1;
        end
    end

    // Operation mode and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            setting_mode_q <= 1'b0;
            search_mode_q  <= 1'b0;
            o_error        <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            setting_mode_q <= i_setting_enable;
            search_mode_q  <= !i_setting_enable;
            o_error        <= 1'b0;
        end else begin
            if ((state_q != S_IDLE) && (state_d == S_IDLE)) begin
                setting_mode_q <= 1'b0;
                search_mode_q  <= 1'b0;
            end
            if (timeout_hit) o_error <= 1'b1;
        end
    end

    assign o_frag_idx         = idx_q;
    assign o_cntl_m0_load     = (state_q == S_IDLE) && reset_n;
    assign o_search_complete  = !search_mode_q;
    assign o_setting_complete = !setting_mode_q;

endmodule

// File: tb/tb_segment_sequencer.sv
// Directed bench for segment_sequencer (FRAGMENTS=5, STABLE_CYCLES=2,
// TIMEOUT_CYCLES=8). A small Avalon responder model supplies waitrequest,
// readdatavalid and modify_done; a monitor counts events per operation.
module tb_segment_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       set_en, srch_en;
    logic       waitreq, rdv, modify_done, miss;
    logic       rd, wr, load, shift, modify, sdv, busy, srch_cmp, set_cmp, done, err;
    logic [2:0] idx;

    always #5 clk = ~clk;

    segment_sequencer #(
        .FRAGMENTS(5), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_setting_enable(set_en), .i_search_enable(srch_en),
        .i_sdram_waitrequest(waitreq), .i_sdram_readdatavalid(rdv),
        .o_sdram_read(rd), .o_sdram_write(wr),
        .i_cntl_m0_modify_done(modify_done), .i_search_miss(miss),
        .o_cntl_m0_load(load), .o_cntl_m0_shift(shift), .o_cntl_m0_modify(modify),
        .o_cntl_m0_searchdatavalid(sdv), .o_frag_idx(idx), .o_busy(busy),
        .o_search_complete(srch_cmp), .o_setting_complete(set_cmp),
        .o_done(done), .o_error(err)
    );

    // Responder model
    int         wr_hold = 0;
    bit         rdv_en  = 1'b1;
    bit         miss_en = 1'b0;
    logic [7:0] wcnt    = '0;
    int         cyc     = 0;
    assign waitreq     = (rd || wr) && (int'(wcnt) < wr_hold);
    assign modify_done = modify;
    assign miss        = miss_en && (idx == 3'd1);

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        wcnt <= (rd || wr) ? wcnt + 8'd1 : 8'd0;
        rdv  <= rdv_en && rd && !waitreq;
    end

    // Event monitor
    int sdv_cnt, rd_cyc, wr_cyc, rd_rise, mod_cyc, done_cnt, done_cyc, err_cyc;
    int sdv_idx[$];
    logic rd_prev = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (sdv) begin sdv_cnt++; sdv_idx.push_back(int'(idx)); end
            if (rd) rd_cyc++;
            if (rd && !rd_prev) rd_rise++;
            rd_prev = rd;
            if (wr) wr_cyc++;
            if (modify) mod_cyc++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err && err_cyc < 0) err_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int start_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        sdv_cnt = 0; rd_cyc = 0; wr_cyc = 0; rd_rise = 0; mod_cyc = 0;
        done_cnt = 0; done_cyc = -1; err_cyc = -1;
        sdv_idx.delete();
    endtask

    // Present a start request for one sampling edge; start_cyc marks that edge.
    task automatic start_op(input bit s, input bit q);
        @(negedge clk);
        set_en = s; srch_en = q;
        @(posedge clk); #1;
        start_cyc = cyc;
        set_en = 1'b0; srch_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0; set_en = 1'b0; srch_en = 1'b0;
        clear_mon();

        // Reset and release
        repeat (3) @(posedge clk);
        #2;
        check("rst_load_in_reset", load, 0);
        check("rst_busy_in_reset", busy, 0);
        reset_n = 1'b1;
        @(posedge clk); #2;
        check("rst_load", load, 1);
        check("rst_srch_cmp", srch_cmp, 1);
        check("rst_set_cmp", set_cmp, 1);
        check("rst_idx", idx, 0);
        check("rst_reqs", {rd, wr, shift, modify, sdv, done, err, busy}, 0);

        // Search, zero waitrequest, immediate readdatavalid
        clear_mon();
        start_op(1'b0, 1'b1);
        check("srch_cmp_busy", srch_cmp, 0);
        check("srch_load_busy", load, 0);
        wait_done("srch", 60);
        check("srch_latency", done_cyc - start_cyc, 30);
        check("srch_sdv_cnt", sdv_cnt, 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("srch_sdv_idx%0d", i), (i < sdv_idx.size()) ? sdv_idx[i] : -1, i);
        check("srch_done_cnt", done_cnt, 1);
        check("srch_no_write", wr_cyc, 0);
        check("srch_err", err, 0);
        check("srch_idle", {busy, load, srch_cmp}, 3'b011);

        // Setting, waitrequest held 3 cycles on every access
        clear_mon();
        wr_hold = 3;
        start_op(1'b1, 1'b0);
        check("set_cmp_busy", set_cmp, 0);
        wait_done("set_wait", 150);
        check("set_wait_latency", done_cyc - start_cyc, 75);
        check("set_wait_rd_cyc", rd_cyc, 20);
        check("set_wait_wr_cyc", wr_cyc, 20);
        check("set_wait_rd_rise", rd_rise, 5);
        check("set_wait_mod_cyc", mod_cyc, 5);
        check("set_wait_sdv", sdv_cnt, 0);
        check("set_wait_err", err, 0);
        wr_hold = 0;

        // Timeout: readdatavalid withheld
        clear_mon();
        rdv_en = 1'b0;
        start_op(1'b0, 1'b1);
        wait_done("tmo", 40);
        check("tmo_err_cyc", err_cyc - start_cyc, 12);
        check("tmo_done_cyc", done_cyc - start_cyc, 12);
        check("tmo_err_sticky", err, 1);
        check("tmo_idle", {busy, load, rd}, 3'b010);
        rdv_en = 1'b1;
        clear_mon();
        start_op(1'b0, 1'b1);
        check("tmo_err_cleared", err, 0);
        wait_done("tmo_next", 60);
        check("tmo_next_err", err, 0);

        // Both starts together, then a start while busy
        clear_mon();
        start_op(1'b1, 1'b1);
        check("prio_set_cmp", set_cmp, 0);
        check("prio_srch_cmp", srch_cmp, 1);
        repeat (5) @(posedge clk);
        @(negedge clk); srch_en = 1'b1;
        @(negedge clk); srch_en = 1'b0;
        wait_done("prio", 100);
        check("prio_latency", done_cyc - start_cyc, 45);
        check("prio_mod_cyc", mod_cyc, 5);
        repeat (6) @(posedge clk);
        #2;
        check("prio_no_restart", {busy, 32'(done_cnt)}, 1);

        // Search miss at fragment 1
        clear_mon();
        miss_en = 1'b1;
        start_op(1'b0, 1'b1);
        wait_done("miss", 60);
`ifdef SEGSEQ_EARLY_EXIT_EN
        check("miss_sdv_cnt", sdv_cnt, 2);
        check("miss_latency", done_cyc - start_cyc, 12);
`else
        check("miss_sdv_cnt", sdv_cnt, 5);
        check("miss_latency", done_cyc - start_cyc, 30);
`endif
        check("miss_err", err, 0);
        miss_en = 1'b0;

        // Reset in mid-operation
        clear_mon();
        start_op(1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_outs", {busy, shift, rd, done, load}, 0);
        check("midrst_idx", idx, 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("midrst_no_done", done_cnt, 0);
        check("midrst_idle", {busy, load, srch_cmp, set_cmp}, 4'b0111);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
